// File: rtl/gear_shift_scheduler.sv
// Gear shift scheduler: edge-detected manual/auto requests, one pending slot, timed actuator drive and settle.
// Optional auto-request path enabled by defining GEAR_SHIFT_AUTO_EN.
module gear_shift_scheduler #(
  parameter int unsigned MIN_GEAR      = 1,
  parameter int unsigned MAX_GEAR      = 9,
  parameter int unsigned PULSE_CYCLES  = 50,
  parameter int unsigned SETTLE_CYCLES = 200,
  localparam int unsigned GEAR_W       = 4,
  localparam int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              up_req,
  input  logic              down_req,
  input  logic              auto_up,
  input  logic              auto_down,
  input  logic              auto_mode,
  input  logic              act_ready,
  output logic [GEAR_W-1:0] gear,
  output logic              out1,
  output logic              out2,
  output logic              busy,
  output logic              limit_hit
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACT = 2'd1,
    DRIVE    = 2'd2,
    SETTLE   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               slot_vld_q, slot_vld_d;
  logic               slot_up_q, slot_up_d;
  logic               dir_up_q, dir_up_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GEAR_W-1:0]  gear_q, gear_d;
  logic               out1_q, out1_d;
  logic               out2_q, out2_d;
  logic               busy_q, busy_d;
  logic               limit_q, limit_d;
  logic               up_prev_q, dn_prev_q;
  logic               up_edge_q, up_edge_d;
  logic               dn_edge_q, dn_edge_d;
  logic               primed_q;

  logic auto_up_c, auto_dn_c;
  logic req_vld_c, req_up_c;
  logic eff_vld_c, eff_up_c;
  logic at_limit_c;

`ifdef GEAR_SHIFT_AUTO_EN
  assign auto_up_c = auto_mode & auto_up;
  assign auto_dn_c = auto_mode & auto_down;
`else
  logic auto_unused_c;
  assign auto_unused_c = auto_mode ^ auto_up ^ auto_down;
  assign auto_up_c     = 1'b0;
  assign auto_dn_c     = 1'b0;
`endif

  // Edges are suppressed on the first cycle after reset so a held button stays silent.
  assign up_edge_d = primed_q & up_req & ~up_prev_q;
  assign dn_edge_d = primed_q & down_req & ~dn_prev_q;

  // Merge sources (manual wins), then fold the new request into the pending slot.
  always_comb begin
    req_vld_c = 1'b0;
    req_up_c  = 1'b0;
    if (up_edge_q | dn_edge_q) begin
      req_vld_c = up_edge_q ^ dn_edge_q;
      req_up_c  = up_edge_q;
    end else begin
      req_vld_c = auto_up_c ^ auto_dn_c;
      req_up_c  = auto_up_c;
    end

    eff_vld_c = slot_vld_q;
    eff_up_c  = slot_up_q;
    if (req_vld_c) begin
      if (slot_vld_q && (slot_up_q != req_up_c)) begin
        eff_vld_c = 1'b0;
      end else begin
        eff_vld_c = 1'b1;
        eff_up_c  = req_up_c;
      end
    end

    at_limit_c = eff_up_c ? (gear_q >= GEAR_W'(MAX_GEAR)) : (gear_q <= GEAR_W'(MIN_GEAR));
  end

  always_comb begin
    state_d    = state_q;
    slot_vld_d = eff_vld_c;
    slot_up_d  = eff_up_c;
    dir_up_d   = dir_up_q;
    cnt_d      = cnt_q;
    gear_d     = gear_q;
    out1_d     = 1'b0;
    out2_d     = 1'b0;
    limit_d    = 1'b0;

    unique case (state_q)
      IDLE, WAIT_ACT: begin
        if (eff_vld_c && at_limit_c) begin
          slot_vld_d = 1'b0;
          limit_d    = 1'b1;
          state_d    = IDLE;
        end else if (eff_vld_c && act_ready) begin
          state_d    = DRIVE;
          slot_vld_d = 1'b0;
          dir_up_d   = eff_up_c;
          cnt_d      = CNT_W'(PULSE_CYCLES);
          out1_d     = eff_up_c;
          out2_d     = ~eff_up_c;
        end else if (eff_vld_c) begin
          state_d = WAIT_ACT;
        end else if (act_ready) begin
          // Slot was cancelled while waiting; nothing left to drive.
          state_d = IDLE;
        end
      end
      DRIVE: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYCLES);
          if (dir_up_q && (gear_q < GEAR_W'(MAX_GEAR))) begin
            gear_d = gear_q + GEAR_W'(1);
          end else if (!dir_up_q && (gear_q > GEAR_W'(MIN_GEAR))) begin
            gear_d = gear_q - GEAR_W'(1);
          end
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          out1_d = dir_up_q;
          out2_d = ~dir_up_q;
        end
      end
      SETTLE: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      slot_vld_q <= 1'b0;
      slot_up_q  <= 1'b0;
      dir_up_q   <= 1'b0;
      cnt_q      <= '0;
      gear_q     <= GEAR_W'(MIN_GEAR);
      out1_q     <= 1'b0;
      out2_q     <= 1'b0;
      busy_q     <= 1'b0;
      limit_q    <= 1'b0;
      up_prev_q  <= 1'b0;
      dn_prev_q  <= 1'b0;
      up_edge_q  <= 1'b0;
      dn_edge_q  <= 1'b0;
      primed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_vld_q <= slot_vld_d;
      slot_up_q  <= slot_up_d;
      dir_up_q   <= dir_up_d;
      cnt_q      <= cnt_d;
      gear_q     <= gear_d;
      out1_q     <= out1_d;
      out2_q     <= out2_d;
      busy_q     <= busy_d;
      limit_q    <= limit_d;
      up_prev_q  <= up_req;
      dn_prev_q  <= down_req;
      up_edge_q  <= up_edge_d;
      dn_edge_q  <= dn_edge_d;
      primed_q   <= 1'b1;
    end
  end

  assign gear      = gear_q;
  assign out1      = out1_q;
  assign out2      = out2_q;
  assign busy      = busy_q;
  assign limit_hit = limit_q;

endmodule

// File: tb/tb_gear_shift_scheduler.sv
// Directed bench for gear_shift_scheduler with PULSE_CYCLES=4, SETTLE_CYCLES=6.
// Auto-path expectations follow GEAR_SHIFT_AUTO_EN.
module tb_gear_shift_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       up_req = 1'b0, down_req = 1'b0;
  logic       auto_up = 1'b0, auto_down = 1'b0, auto_mode = 1'b0;
  logic       act_ready = 1'b1;
  logic [3:0] gear;
  logic       out1, out2, busy, limit_hit;

  int checks = 0;
  int failures = 0;

  gear_shift_scheduler #(
    .MIN_GEAR(1), .MAX_GEAR(9), .PULSE_CYCLES(4), .SETTLE_CYCLES(6)
  ) dut (
    .clk(clk), .reset(reset), .up_req(up_req), .down_req(down_req),
    .auto_up(auto_up), .auto_down(auto_down), .auto_mode(auto_mode),
    .act_ready(act_ready), .gear(gear), .out1(out1), .out2(out2),
    .busy(busy), .limit_hit(limit_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       up, dn, act;
    logic       o1, o2, bz, lh;
    logic [3:0] g;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic up, input logic dn, input logic act,
                              input logic o1, input logic o2, input logic bz,
                              input logic lh, input logic [3:0] g);
    vec_t v;
    v.up = up; v.dn = dn; v.act = act;
    v.o1 = o1; v.o2 = o2; v.bz = bz; v.lh = lh; v.g = g;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (busy && n < max_cycles) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic shift_up();
    up_req = 1'b1;
    tick();
    up_req = 1'b0;
    tick();
    wait_idle(40);
  endtask

  logic seen;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    // Single up press trace: out1 high for 4 cycles starting two cycles after the edge.
    for (int i = 0; i < 12; i++) begin
      logic u;
      u = (i < 3);
      if (i == 0)       vq.push_back(mk(u, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1));
      else if (i <= 4)  vq.push_back(mk(u, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1));
      else if (i <= 10) vq.push_back(mk(u, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2));
      else              vq.push_back(mk(u, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2));
    end
    // Down press held in WAIT_ACT for 11 cycles, then drive once act_ready rises.
    for (int i = 0; i < 22; i++) begin
      logic d, a;
      d = (i == 0);
      a = (i >= 11);
      if (i == 0)       vq.push_back(mk(1'b0, d, a, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2));
      else if (i <= 10) vq.push_back(mk(1'b0, d, a, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2));
      else if (i <= 14) vq.push_back(mk(1'b0, d, a, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2));
      else if (i <= 20) vq.push_back(mk(1'b0, d, a, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1));
      else              vq.push_back(mk(1'b0, d, a, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1));
    end

    #3 reset = 1'b0;
    #2;
    chk("reset_gear", 32'(gear), 32'd1);
    chk("reset_out1", 32'(out1), 32'd0);
    chk("reset_out2", 32'(out2), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_limit", 32'(limit_hit), 32'd0);
    repeat (3) @(posedge clk);
    #4 reset = 1'b1;
    tick();
    tick();

    foreach (vq[i]) begin
      up_req    = vq[i].up;
      down_req  = vq[i].dn;
      act_ready = vq[i].act;
      tick();
      checks++;
      if ({out1, out2, busy, limit_hit, gear} !== {vq[i].o1, vq[i].o2, vq[i].bz, vq[i].lh, vq[i].g}) begin
        failures++;
        $display("FAIL vec[%0d] actual o1=%b o2=%b busy=%b lim=%b gear=%0d expected o1=%b o2=%b busy=%b lim=%b gear=%0d",
                 i, out1, out2, busy, limit_hit, gear,
                 vq[i].o1, vq[i].o2, vq[i].bz, vq[i].lh, vq[i].g);
      end
    end
    up_req = 1'b0; down_req = 1'b0; act_ready = 1'b1;
    tick();

    // Down at MIN_GEAR: single-cycle limit_hit, no drive.
    down_req = 1'b1;
    tick();
    chk("min_lim_early", 32'(limit_hit), 32'd0);
    down_req = 1'b0;
    tick();
    chk("min_lim_pulse", 32'(limit_hit), 32'd1);
    chk("min_busy", 32'(busy), 32'd0);
    tick();
    chk("min_lim_drop", 32'(limit_hit), 32'd0);
    chk("min_gear", 32'(gear), 32'd1);
    chk("min_out2", 32'(out2), 32'd0);

    // Simultaneous up and down edges cancel.
    up_req = 1'b1; down_req = 1'b1;
    tick();
    up_req = 1'b0; down_req = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      tick();
      seen |= busy | limit_hit | out1 | out2;
    end
    chk("cancel_quiet", 32'(seen), 32'd0);
    chk("cancel_gear", 32'(gear), 32'd1);

    // Up then down during the same SETTLE: slot clears, no second shift.
    up_req = 1'b1;
    tick();
    up_req = 1'b0;
    tick();
    for (int k = 0; k < 10 && out1; k++) tick();
    chk("settle_entry_gear", 32'(gear), 32'd2);
    chk("settle_entry_busy", 32'(busy), 32'd1);
    up_req = 1'b1;   tick();
    up_req = 1'b0;   tick();
    down_req = 1'b1; tick();
    down_req = 1'b0; tick();
    wait_idle(20);
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen |= busy | out1 | out2 | limit_hit;
    end
    chk("settle_cancel_quiet", 32'(seen), 32'd0);
    chk("settle_cancel_gear", 32'(gear), 32'd2);

`ifdef GEAR_SHIFT_AUTO_EN
    // Manual down edge beats a same-cycle auto_up.
    auto_mode = 1'b1;
    down_req = 1'b1;
    tick();
    down_req = 1'b0;
    auto_up = 1'b1;
    tick();
    auto_up = 1'b0;
    chk("prio_out2", 32'(out2), 32'd1);
    chk("prio_out1", 32'(out1), 32'd0);
    wait_idle(30);
    chk("prio_gear", 32'(gear), 32'd1);
    // Auto request drives one cycle after the pulse.
    auto_up = 1'b1;
    tick();
    auto_up = 1'b0;
    chk("auto_latency_out1", 32'(out1), 32'd1);
    wait_idle(30);
    chk("auto_gear", 32'(gear), 32'd2);
    auto_mode = 1'b0;
`else
    auto_mode = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      auto_up = 1'b1;
      tick();
      seen |= busy | out1;
      auto_up = 1'b0;
      tick();
      seen |= busy | out1;
    end
    auto_mode = 1'b0;
    chk("auto_ignored_quiet", 32'(seen), 32'd0);
    chk("auto_ignored_gear", 32'(gear), 32'd2);
`endif

    // Climb to MAX_GEAR, then an up press only raises limit_hit.
    for (int g = 2; g < 9; g++) begin
      shift_up();
      chk("climb_gear", 32'(gear), 32'(g + 1));
    end
    up_req = 1'b1;
    tick();
    up_req = 1'b0;
    tick();
    chk("max_lim_pulse", 32'(limit_hit), 32'd1);
    chk("max_busy", 32'(busy), 32'd0);
    tick();
    chk("max_lim_drop", 32'(limit_hit), 32'd0);
    chk("max_gear", 32'(gear), 32'd9);

    // Reset mid-DRIVE at gear 3 with the button still held.
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    tick();
    tick();
    chk("rst_gear", 32'(gear), 32'd1);
    shift_up();
    shift_up();
    chk("pre_drive_gear", 32'(gear), 32'd3);
    up_req = 1'b1;
    tick();
    tick();
    chk("mid_drive_out1", 32'(out1), 32'd1);
    tick();
    #2 reset = 1'b0;
    #1;
    chk("async_out1", 32'(out1), 32'd0);
    chk("async_out2", 32'(out2), 32'd0);
    chk("async_gear", 32'(gear), 32'd1);
    #1 reset = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      tick();
      seen |= busy | out1 | out2;
    end
    chk("held_quiet", 32'(seen), 32'd0);
    chk("held_gear", 32'(gear), 32'd1);
    up_req = 1'b0;
    tick();
    shift_up();
    chk("repress_gear", 32'(gear), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
